// File: rtl/demux_dispatch_ctrl_if.sv
// demux_dispatch_ctrl_if: producer/consumer handshake bundle
// for the 8-way dispatch controller.
interface demux_dispatch_ctrl_if #(
  parameter int DW  = 8,
  parameter int NCH = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_data;
  logic [2:0]     in_sel;
  logic [NCH-1:0] out_valid;
  logic [NCH-1:0] out_ready;
  logic [DW-1:0]  out_data;

  modport master (
    output in_valid, in_data, in_sel,
    output out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_sel,
    input  out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// demux_dispatch_ctrl: one-deep 1-to-8 dispatcher with
// directed / round-robin routing and a drop counter.
module demux_dispatch_ctrl #(
  parameter int DW  = 8,
  parameter int NCH = 8,
  parameter int CW  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mode,
  input  logic [NCH-1:0]      chan_en,
  demux_dispatch_ctrl_if.slave bus,
  output logic [CW-1:0]       drop_cnt
);

  logic          full;
  logic [DW-1:0] hold_data;
  logic [2:0]    hold_sel;
  logic [2:0]    rr_ptr;
  logic [2:0]    rr_dest;
  logic [2:0]    dest;
  logic          dest_ok;
  logic          out_fire;
  logic          acc;
  logic          rr_stall;

  assign bus.out_valid = full ? (NCH'(1) << hold_sel) : '0;
  assign bus.out_data  = hold_data;

  assign out_fire = full && bus.out_ready[hold_sel];
  assign rr_stall = mode && (chan_en == '0);
  assign bus.in_ready = !rr_stall && (!full || out_fire);
  assign acc = bus.in_valid && bus.in_ready;

  // first enabled channel at or after rr_ptr, wrapping;
  // scan from farthest so the nearest hit wins
  always_comb begin
    rr_dest = rr_ptr;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (chan_en[rr_ptr + 3'(i)])
        rr_dest = rr_ptr + 3'(i);
    end
  end

  // resolve destination for this cycle's input item
  always_comb begin
    dest    = bus.in_sel;
    dest_ok = chan_en[bus.in_sel];
    if (mode) begin
      dest    = rr_dest;
      dest_ok = |chan_en;
    end
  end

  // holding register, full flag and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full      <= 1'b0;
      hold_data <= '0;
      hold_sel  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (acc && dest_ok) begin
        full      <= 1'b1;
        hold_data <= bus.in_data;
        hold_sel  <= dest;
        if (mode)
          rr_ptr <= dest + 3'd1;
      end else if (out_fire) begin
        full <= 1'b0;
      end
    end
  end

  // saturating count of items accepted to a disabled channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (acc && !dest_ok) begin
      if (drop_cnt != {CW{1'b1}})
        drop_cnt <= drop_cnt + CW'(1);
    end
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
- Sequences an 8-way 1-to-N demux datapath.
- Accepts a single input stream under a valid/ready handshake and routes each item to exactly one of 8 output channels.
- Channel choice is either directed by a select field or by round-robin over enabled channels.
- Sits between a single producer and 8 consumer lanes. Provides one item of buffering, a per-channel enable mask and a dropped-item counter.

Parameters:
- DW, 8, data width of each item.
- NCH, 8, number of output channels; fixed at 8 for this revision, select width 3.
- CW, 8, width of the dropped-item counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = directed (use in_sel), 1 = round-robin.
- chan_en  input  8  per-channel enable mask; bit k enables channel k.
- in_valid  input  1  producer has an item.
- in_ready  output  1  controller can accept an item this cycle.
- in_data  input  DW  item payload.
- in_sel  input  3  destination channel, used only when mode=0.
- out_valid  output  8  one-hot valid; bit k = item presented to channel k.
- out_ready  input  8  per-channel consumer ready.
- out_data  output  DW  payload, shared by all channels; qualified by out_valid.
- drop_cnt  output  CW  saturating count of dropped items.

Behaviour:
- State:
  - Holding register {hold_data, hold_sel}.
  - full flag.
  - rr_ptr (3 bits).
  - drop_cnt.
- Reset (async, rst_n=0):
  - full=0, out_valid=0, out_data=0, hold_sel=0, rr_ptr=0, drop_cnt=0.
  - in_ready is a combinational function of state and follows the rule below.
- Output side:
  - out_valid[k] = full && (hold_sel==k); at most one bit set.
  - out_data = hold_data.
  - Output fire: out_fire = full && out_ready[hold_sel].
- Destination resolution, evaluated each cycle from current inputs:
  - mode=0: dest = in_sel; dest_ok = chan_en[in_sel].
  - mode=1: dest = first k with chan_en[k]=1 searching rr_ptr, rr_ptr+1, ... mod 8 (wraps 7->0); dest_ok = |chan_en.
- Input side:
  - in_ready = !full || out_fire, with one exception: mode=1 with chan_en==0 forces in_ready=0 (stall, never drop in round-robin).
  - Accept: acc = in_valid && in_ready.
- On accept with dest_ok=1:
  - hold_data<=in_data, hold_sel<=dest, full<=1.
  - In mode=1 only, rr_ptr<=dest+1 mod 8.
  - Latency: item visible on out_valid the cycle after acceptance.
- On accept with dest_ok=0 (only possible in mode=0):
  - Item discarded and drop_cnt increments, saturating at 2^CW-1.
  - full<=0 if out_fire this cycle, else full unchanged.
- out_fire without accept: full<=0.
- Simultaneous out_fire and accept: the holding register is reloaded, so full stays 1 and throughput is 1 item/cycle.
- Backpressure: while full && !out_ready[hold_sel], in_ready=0. The held item, hold_sel and hold_data stay stable until the fire.
- chan_en or mode changes while full do not affect the held item; it is delivered to hold_sel even if that channel is disabled. New settings apply only to the next accept.
- rr_ptr is unchanged by mode=0 traffic.
- Reset mid-transfer: the held item is lost and out_valid drops to 0 immediately (asynchronously).

Test Plan:
- Directed sweep: mode=0, chan_en=8'hFF, all out_ready=1, in_sel=0..7 back-to-back, in_data=8'hA0+sel -> out_valid=1<<sel one cycle after each accept, data matches, in_ready=1 every cycle, drop_cnt=0.
- Round-robin with mask: mode=1, chan_en=8'b1010_0101, out_ready=8'hFF, 6 items -> channels 0,2,5,7,0,2 in order, rr_ptr=3 at end.
- Backpressure: mode=0, in_sel=3, out_ready[3]=0 for 4 cycles then 1 -> out_valid=8'h08 held, hold_data stable, in_ready=0 during stall; next item accepted on the release cycle.
- Drop and saturation: CW=8, mode=0, chan_en=8'hFE, 300 items with in_sel=0 -> no out_valid, drop_cnt reaches 255 and stays 255, in_ready stays 1.
- Empty mask stall: mode=1, chan_en=0, in_valid=1 -> in_ready=0, drop_cnt unchanged. Setting chan_en=8'h10 -> accepted, out_valid=8'h10.
- Async reset: with full=1 and out_valid=8'h04, pulse rst_n low between clock edges -> out_valid=0 and drop_cnt=0 immediately. After release, the first round-robin item goes to the lowest enabled channel at or after 0.
